// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller: panel modes, access FSM
// encoding and requester select values.
package mem_ctrl_pkg;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_IN    = 2'b01;
    localparam logic [1:0] MODE_CHECK = 2'b10;
    localparam logic [1:0] MODE_RUN   = 2'b11;

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_SETUP  = 2'd1,
        A_STROBE = 2'd2,
        A_DONE   = 2'd3
    } acc_state_e;

    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU request bus and memory strobe bus seen by the memory controller.
// master = the controller, slave = the CPU core plus memory block.
interface mem_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_ack, cpu_rdata, mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_ack, cpu_rdata, mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_ctrl_key_edge.sv
// Panel key synchroniser: two metastability flops, then a falling-edge
// detector producing a single-cycle key_pulse. Flops preset to 1 (released key).
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_pulse
);
    logic s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;

    always_comb begin
        s1_d = key_n;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign key_pulse = s3_q & ~s2_q;
endmodule

// File: rtl/mem_ctrl.sv
// Memory access sequencer shared between the front-panel loader (IN/CHECK)
// and the CPU bus (RUN); each access is SETUP -> STROBE -> DONE.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int LOAD_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    mode_sel,
    input  logic                          key_n,
    input  logic [DATA_W-1:0]             sw_d,
    mem_ctrl_if.master                    bus,
    output logic [1:0]                    cpustate,
    output logic [$clog2(LOAD_DEPTH)-1:0] load_cnt,
    output logic                          load_wrap,
    output logic [DATA_W-1:0]             check_data
);
    localparam int LCNT_W = $clog2(LOAD_DEPTH);

    acc_state_e        state_q, state_d;
    logic [1:0]        cpustate_q, cpustate_d;
    logic [LCNT_W-1:0] load_cnt_q, load_cnt_d, cnt_inc;
    logic              load_wrap_q, load_wrap_d;
    logic              key_pend_q, key_pend_d;
    logic              chk_auto_q, chk_auto_d;
    logic              sel_q, sel_d, we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, check_data_q, check_data_d;
    logic              key_pulse, mode_chg, rd_done;

    key_edge u_key_edge (.clk(clk), .reset(reset), .key_n(key_n), .key_pulse(key_pulse));

    assign cnt_inc  = load_cnt_q + 1'b1;
    // Mode changes only land between accesses and pre-empt a grant in that cycle.
    assign mode_chg = (state_q == A_IDLE) && (mode_sel != cpustate_q);
    assign rd_done  = (state_q == A_DONE) && !we_q;

    always_comb begin
        state_d      = state_q;
        cpustate_d   = cpustate_q;
        load_cnt_d   = load_cnt_q;
        load_wrap_d  = load_wrap_q;
        key_pend_d   = key_pend_q;
        chk_auto_d   = chk_auto_q;
        sel_d        = sel_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        check_data_d = check_data_q;

        if (mode_chg) begin
            cpustate_d = mode_sel;
            chk_auto_d = (mode_sel == MODE_CHECK);
            if (mode_sel == MODE_IN || mode_sel == MODE_CHECK) begin
                load_cnt_d = '0;
                key_pend_d = 1'b0;
            end
            if (mode_sel == MODE_IN) load_wrap_d = 1'b0;
        end

        if (key_pulse) key_pend_d = 1'b1;

        unique case (state_q)
            A_IDLE: if (!mode_chg) begin
                if (cpustate_q == MODE_RUN && bus.cpu_req) begin
                    sel_d       = REQ_CPU;
                    we_d        = bus.cpu_we;
                    mem_addr_d  = bus.cpu_addr;
                    mem_wdata_d = bus.cpu_wdata;
                    state_d     = A_SETUP;
                end else if (cpustate_q == MODE_IN && key_pend_q) begin
                    sel_d       = REQ_LOAD;
                    we_d        = 1'b1;
                    mem_addr_d  = ADDR_W'(load_cnt_q);
                    mem_wdata_d = sw_d;
                    state_d     = A_SETUP;
                end else if (cpustate_q == MODE_CHECK && chk_auto_q) begin
                    sel_d      = REQ_LOAD;
                    we_d       = 1'b0;
                    mem_addr_d = ADDR_W'(load_cnt_q);
                    chk_auto_d = 1'b0;
                    state_d    = A_SETUP;
                end else if (cpustate_q == MODE_CHECK && key_pend_q) begin
                    sel_d      = REQ_LOAD;
                    we_d       = 1'b0;
                    load_cnt_d = cnt_inc;
                    mem_addr_d = ADDR_W'(cnt_inc);
                    key_pend_d = 1'b0;
                    state_d    = A_SETUP;
                end
            end
            A_SETUP: begin
                mem_rd_d = !we_q;
                mem_wr_d = we_q;
                state_d  = A_STROBE;
            end
            A_STROBE: state_d = A_DONE;
            A_DONE: begin
                state_d = A_IDLE;
                if (sel_q == REQ_CPU) begin
                    if (!we_q) cpu_rdata_d = bus.mem_rdata;
                end else if (we_q) begin
                    load_cnt_d = cnt_inc;
                    key_pend_d = 1'b0;
                    if (&load_cnt_q) load_wrap_d = 1'b1;
                end else begin
                    check_data_d = bus.mem_rdata;
                end
            end
            default: state_d = A_IDLE;
        endcase

        // RUN owns the memory; panel presses are meaningless there.
        if (cpustate_d == MODE_RUN) key_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= A_IDLE;
            cpustate_q   <= MODE_IDLE;
            load_cnt_q   <= '0;
            load_wrap_q  <= 1'b0;
            key_pend_q   <= 1'b0;
            chk_auto_q   <= 1'b0;
            sel_q        <= REQ_CPU;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            cpu_rdata_q  <= '0;
            check_data_q <= '0;
        end else begin
            state_q      <= state_d;
            cpustate_q   <= cpustate_d;
            load_cnt_q   <= load_cnt_d;
            load_wrap_q  <= load_wrap_d;
            key_pend_q   <= key_pend_d;
            chk_auto_q   <= chk_auto_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            cpu_rdata_q  <= cpu_rdata_d;
            check_data_q <= check_data_d;
        end
    end

    // Read data is forwarded in the DONE cycle itself, then held by the flops.
    assign bus.cpu_ack   = (state_q == A_DONE) && (sel_q == REQ_CPU);
    assign bus.cpu_rdata = (rd_done && sel_q == REQ_CPU) ? bus.mem_rdata : cpu_rdata_q;
    assign check_data    = (rd_done && sel_q == REQ_LOAD) ? bus.mem_rdata : check_data_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign cpustate      = cpustate_q;
    assign load_cnt      = load_cnt_q;
    assign load_wrap     = load_wrap_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: loader write/wrap, CHECK readback, CPU
// latency, gated CPU request and reset during a strobe.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int LOAD_DEPTH = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode_sel;
    logic       key_n;
    logic [7:0] sw_d;
    logic [1:0] cpustate;
    logic [4:0] load_cnt;
    logic       load_wrap;
    logic [7:0] check_data;

    mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_DEPTH(LOAD_DEPTH)) dut (
        .clk(clk), .reset(reset), .mode_sel(mode_sel), .key_n(key_n), .sw_d(sw_d),
        .bus(bus.master), .cpustate(cpustate), .load_cnt(load_cnt),
        .load_wrap(load_wrap), .check_data(check_data)
    );

    always #5 clk = ~clk;

    // Synchronous memory model: read data appears the cycle after mem_rd.
    bit [7:0] mem [0:65535];
    bit [7:0] rdata_q;
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd) rdata_q <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = rdata_q;

    logic [15:0] wr_a[$];
    logic [7:0]  wr_d[$];
    logic [15:0] rd_a[$];
    int ack_n = 0;
    int viol = 0;
    logic strb_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_wr) begin
            wr_a.push_back(bus.mem_addr);
            wr_d.push_back(bus.mem_wdata);
        end
        if (bus.mem_rd) rd_a.push_back(bus.mem_addr);
        if (bus.cpu_ack) ack_n++;
        if ((bus.mem_rd && bus.mem_wr) || ((bus.mem_rd || bus.mem_wr) && strb_prev)) viol++;
        strb_prev = bus.mem_rd | bus.mem_wr;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {13'b0, cpustate, load_cnt, load_wrap, check_data, bus.cpu_ack, bus.cpu_rdata,
                bus.mem_addr, bus.mem_wdata, bus.mem_rd, bus.mem_wr};
    endfunction

    task automatic press();
        key_n = 1'b0;
        repeat (4) @(negedge clk);
        key_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic cpu_acc(input logic we, input logic [15:0] a, input logic [7:0] d,
                           output int lat, output int strb_cyc, output logic [7:0] rd);
        lat = 0;
        strb_cyc = 0;
        rd = '0;
        bus.cpu_req = 1'b1;
        bus.cpu_we = we;
        bus.cpu_addr = a;
        bus.cpu_wdata = d;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if ((bus.mem_wr || bus.mem_rd) && strb_cyc == 0) strb_cyc = k;
            if (bus.cpu_ack) begin
                lat = k;
                rd = bus.cpu_rdata;
                break;
            end
        end
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        int base, rbase, lat, sc, a0, seen;
        logic [7:0] rd;

        reset = 1'b0;
        mode_sel = MODE_IDLE;
        key_n = 1'b1;
        sw_d = '0;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // IN mode: two loader writes
        mode_sel = MODE_IN;
        repeat (2) @(negedge clk);
        chk("in_cpustate", cpustate, 2'b01);
        chk("in_cnt_start", load_cnt, 0);
        base = wr_a.size();
        sw_d = 8'hA5; press();
        sw_d = 8'h3C; press();
        chk("in_wr_count", wr_a.size() - base, 2);
        chk("in_wr0_addr", wr_a[base], 16'h0000);
        chk("in_wr0_data", wr_d[base], 8'hA5);
        chk("in_wr1_addr", wr_a[base+1], 16'h0001);
        chk("in_wr1_data", wr_d[base+1], 8'h3C);
        chk("in_cnt_2", load_cnt, 2);
        chk("in_nowrap", load_wrap, 0);

        // Re-enter IN, fill the full loader range
        mode_sel = MODE_IDLE;
        repeat (2) @(negedge clk);
        chk("idle_cpustate", cpustate, 2'b00);
        mode_sel = MODE_IN;
        repeat (2) @(negedge clk);
        chk("reenter_cnt_clr", load_cnt, 0);
        base = wr_a.size();
        for (int i = 0; i < 32; i++) begin
            sw_d = (i == 0) ? 8'hA5 : (i == 1) ? 8'h3C : 8'(8'h10 + i);
            press();
            if (i == 30) begin
                chk("cnt_31", load_cnt, 31);
                chk("wrap_not_yet", load_wrap, 0);
            end
        end
        chk("wrap_wr_count", wr_a.size() - base, 32);
        chk("wrap_last_addr", wr_a[base+31], 16'd31);
        chk("wrap_last_data", wr_d[base+31], 8'h2F);
        chk("wrap_cnt_0", load_cnt, 0);
        chk("wrap_flag", load_wrap, 1);

        // CHECK mode: automatic read of address 0, then one press
        rbase = rd_a.size();
        mode_sel = MODE_CHECK;
        repeat (8) @(negedge clk);
        chk("chk_cpustate", cpustate, 2'b10);
        chk("chk_auto_rd_n", rd_a.size() - rbase, 1);
        chk("chk_auto_addr", rd_a[rbase], 16'h0000);
        chk("chk_auto_data", check_data, 8'hA5);
        chk("chk_wrap_kept", load_wrap, 1);
        press();
        chk("chk_key_addr", rd_a[rbase+1], 16'h0001);
        chk("chk_key_data", check_data, 8'h3C);
        chk("chk_key_cnt", load_cnt, 1);

        // RUN mode: CPU write then read
        mode_sel = MODE_RUN;
        repeat (2) @(negedge clk);
        chk("run_cpustate", cpustate, 2'b11);
        cpu_acc(1'b1, 16'h0040, 8'h77, lat, sc, rd);
        chk("cpu_wr_lat", lat, 3);
        chk("cpu_wr_strobe_cyc", sc, 2);
        chk("cpu_wr_mem", mem[16'h0040], 8'h77);
        @(negedge clk);
        cpu_acc(1'b0, 16'h0040, 8'h00, lat, sc, rd);
        chk("cpu_rd_lat", lat, 3);
        chk("cpu_rd_data", rd, 8'h77);
        repeat (2) @(negedge clk);
        chk("cpu_rd_held", bus.cpu_rdata, 8'h77);

        // CPU request outside RUN waits for the mode switch
        mode_sel = MODE_IN;
        repeat (2) @(negedge clk);
        a0 = ack_n;
        base = wr_a.size();
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 16'h0080;
        bus.cpu_wdata = 8'h11;
        repeat (6) @(negedge clk);
        chk("gated_no_ack", ack_n - a0, 0);
        chk("gated_no_wr", wr_a.size() - base, 0);
        mode_sel = MODE_RUN;
        @(negedge clk);
        chk("gated_run", cpustate, 2'b11);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin
                lat = k;
                break;
            end
        end
        bus.cpu_req = 1'b0;
        chk("gated_lat", lat, 3);
        chk("gated_mem", mem[16'h0080], 8'h11);

        // Reset during the strobe of a CPU write
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 16'h0090;
        bus.cpu_wdata = 8'h55;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.mem_wr) begin
                seen = 1;
                break;
            end
        end
        chk("rst_strobe_seen", seen, 1);
        a0 = ack_n;
        reset = 1'b0;
        #1;
        chk("rst_mem_wr_drop", bus.mem_wr, 0);
        chk("rst_outputs_now", outs(), 64'd0);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("rst_outputs_held", outs(), 64'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_ack", ack_n - a0, 0);
        chk("rst_no_write", mem[16'h0090], 8'h00);
        chk("strobe_single_pulse", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
